// File: rtl/vga_frame_reg_writer.sv
// vga_frame_reg_writer
//   Bus initiator for the sprite/score display peripheral. Game logic posts
//   register updates into a shadow bank whenever it likes. On each falling
//   edge of VGA_VS the block replays only the registers that changed since
//   the last frame, so sprite positions never move while a frame is scanned.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   upd_valid/ready   update handshake from game logic
//   upd_addr/data     target shadow register index and its new value
//   VGA_VS            active-low vertical sync from the VGA counters
//   m_chipselect      bus chipselect
//   m_write           bus write strobe
//   m_address         bus register address
//   m_writedata       bus write data, shadow value zero-extended to 32 bits
//   m_waitrequest     responder stall
//   frame_done        one-cycle pulse when a frame's flush ends
//   frame_overrun     sticky flag: a vsync edge arrived while still flushing
module vga_frame_reg_writer #(
  parameter int NUM_REGS = 13,
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [3:0]        upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic              VGA_VS,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic              frame_done,
  output logic              frame_overrun
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [4:0] NREGS5 = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_shadow [NUM_REGS];
  logic [NUM_REGS-1:0] r_dirty;
  logic [NUM_REGS-1:0] r_pend;
  logic                r_vsQ;
  logic                r_overrun;

  logic                w_trig;
  logic                w_accept;
  logic                w_updHit;
  logic [IDX_W-1:0]    w_idx;
  logic [NUM_REGS-1:0] w_idxMask;
  logic [NUM_REGS-1:0] w_setMask;
  logic [NUM_REGS-1:0] w_retireMask;
  logic [NUM_REGS-1:0] w_pendAfter;
  logic                w_retire;

  // Frame trigger is the falling edge of the active-low vsync; holding it low
  // produces only one trigger because r_vsQ follows it down.
  assign w_trig   = r_vsQ & ~VGA_VS;
  assign w_accept = upd_valid & upd_ready;
  assign w_updHit = ({1'b0, upd_addr} < NREGS5);
  assign w_retire = (r_state == S_FLUSH) & ~m_waitrequest;

  // Lowest pending index wins. The loop runs downward so the lowest set bit
  // is the last assignment to stick. r_pend is a snapshot of the dirty bits
  // taken at the trigger, so an update landing in the trigger cycle waits
  // for the next frame instead of joining this flush.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  // Per-index masks used to set dirty on an accepted update and to clear
  // both dirty and pending when the current write retires.
  always_comb begin
    w_idxMask    = NUM_REGS'(1) << w_idx;
    w_setMask    = (w_accept && w_updHit) ? (NUM_REGS'(1) << upd_addr) : '0;
    w_retireMask = w_retire ? w_idxMask : '0;
    w_pendAfter  = r_pend & ~w_idxMask;
  end

  // Bus and handshake outputs are pure decodes of registered state, so they
  // stay steady across a stall: nothing they depend on changes while
  // m_waitrequest is high, and the shadow bank cannot change during a flush
  // because upd_ready is low.
  always_comb begin
    upd_ready     = (r_state != S_FLUSH);
    m_chipselect  = (r_state == S_FLUSH);
    m_write       = (r_state == S_FLUSH);
    m_address     = '0;
    m_writedata   = '0;
    frame_done    = (r_state == S_DONE);
    frame_overrun = r_overrun;
    if (r_state == S_FLUSH) begin
      m_address   = ADDR_W'(w_idx);
      m_writedata = 32'(r_shadow[w_idx]);
    end
  end

  // Shadow bank, dirty tracking and the IDLE/FLUSH/DONE sequencer. A reset
  // mid-flush simply drops everything, including pending dirty bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dirty   <= '0;
      r_pend    <= '0;
      r_vsQ     <= 1'b1;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_vsQ   <= VGA_VS;
      r_dirty <= (r_dirty & ~w_retireMask) | w_setMask;
      if (w_accept && w_updHit) begin
        r_shadow[upd_addr] <= upd_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_pend  <= r_dirty;
            r_state <= (r_dirty != '0) ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          if (w_trig) begin
            r_overrun <= 1'b1;
          end
          if (!m_waitrequest) begin
            r_pend <= w_pendAfter;
            if (w_pendAfter == '0) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (w_trig) begin
            r_overrun <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_reg_writer.sv
// tb_vga_frame_reg_writer
//   Bench for vga_frame_reg_writer. A queue-based model of the frame flush
//   predicts every output on every cycle; directed scenarios add literal
//   expectations on the retired write stream, followed by a randomized run.
module tb_vga_frame_reg_writer;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [3:0]  upd_addr;
  logic [9:0]  upd_data;
  logic        VGA_VS;
  logic        m_chipselect;
  logic        m_write;
  logic [8:0]  m_address;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        frame_done;
  logic        frame_overrun;

  int compared   = 0;
  int mismatched = 0;

  vga_frame_reg_writer dut (
    .clk           (clk),
    .reset         (reset),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_addr      (upd_addr),
    .upd_data      (upd_data),
    .VGA_VS        (VGA_VS),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a shadow array, a dirty flag per register, and a queue
  // holding the addresses still to be written in the current frame.
  logic [9:0] mShadow [13];
  bit         mDirty  [13];
  int         mq [$];
  bit         mDone;
  bit         mOverrun;
  bit         mVsq;
  bit         mValid = 0;

  always @(posedge clk) begin
    bit trig;
    bit ready;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 13; i++) begin
        mShadow[i] = '0;
        mDirty[i]  = 0;
      end
      mDone    = 0;
      mOverrun = 0;
      mVsq     = 1;
      mValid   = 1;
    end else if (mValid) begin
      trig  = mVsq && !VGA_VS;
      ready = (mq.size() == 0);
      if (mq.size() > 0) begin
        if (trig) mOverrun = 1;
        if (!m_waitrequest) begin
          mDirty[mq[0]] = 0;
          void'(mq.pop_front());
          if (mq.size() == 0) mDone = 1;
        end
      end else if (mDone) begin
        if (trig) mOverrun = 1;
        mDone = 0;
      end else if (trig) begin
        for (int i = 0; i < 13; i++) begin
          if (mDirty[i]) mq.push_back(i);
        end
        if (mq.size() == 0) mDone = 1;
      end
      if (ready && upd_valid && upd_addr < 4'd13) begin
        mShadow[upd_addr] = upd_data;
        mDirty[upd_addr]  = 1;
      end
      mVsq = VGA_VS;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("upd_ready",     upd_ready,     (mq.size() == 0));
      checkOutput("m_chipselect",  m_chipselect,  (mq.size() > 0));
      checkOutput("m_write",       m_write,       (mq.size() > 0));
      checkOutput("m_address",     m_address,     (mq.size() > 0) ? mq[0] : 0);
      checkOutput("m_writedata",   m_writedata,   (mq.size() > 0) ? {22'd0, mShadow[mq[0]]} : 32'd0);
      checkOutput("frame_done",    frame_done,    mDone);
      checkOutput("frame_overrun", frame_overrun, mOverrun);
    end
  end

  // Log of retired writes and frame_done pulses for the directed scenarios.
  int wAddr [$];
  int wData [$];
  int wCyc  [$];
  int cyc        = 0;
  int doneCount  = 0;
  int csCycles   = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset && m_chipselect && m_write && !m_waitrequest) begin
      wAddr.push_back(int'(m_address));
      wData.push_back(int'(m_writedata));
      wCyc.push_back(cyc);
    end
    if (!reset && frame_done) doneCount++;
  end

  always @(negedge clk) begin
    if (!reset && m_chipselect) csCycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Post one update to game-logic side for a single cycle.
  task automatic applyStimulus(input int addr, input int data);
    upd_valid = 1'b1;
    upd_addr  = 4'(addr);
    upd_data  = 10'(data);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic clearLog();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
  endtask

  task automatic waitDone(input string name, input int budget);
    int start;
    start = doneCount;
    for (int k = 0; k < budget && doneCount == start; k++) tick();
    checkOutput(name, (doneCount != start), 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int trigCyc;
  int vsTimer;

  initial begin
    reset         = 1'b1;
    upd_valid     = 1'b0;
    upd_addr      = '0;
    upd_data      = '0;
    VGA_VS        = 1'b1;
    m_waitrequest = 1'b0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_cs",      m_chipselect,  0);
    checkOutput("rst_write",   m_write,       0);
    checkOutput("rst_addr",    m_address,     0);
    checkOutput("rst_data",    m_writedata,   0);
    checkOutput("rst_ready",   upd_ready,     1);
    checkOutput("rst_done",    frame_done,    0);
    checkOutput("rst_overrun", frame_overrun, 0);
    reset = 1'b0;
    tick();

    // Three dirty registers flush on consecutive cycles, then frame_done.
    applyStimulus(0, 50);
    applyStimulus(1, 80);
    applyStimulus(10, 3);
    tick();
    clearLog();
    VGA_VS = 1'b0;
    tick();
    trigCyc = cyc;
    waitDone("t2_done", 20);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t2_count", wAddr.size(), 3);
    if (wAddr.size() == 3) begin
      checkOutput("t2_a0", wAddr[0], 0);
      checkOutput("t2_d0", wData[0], 50);
      checkOutput("t2_a1", wAddr[1], 1);
      checkOutput("t2_d1", wData[1], 80);
      checkOutput("t2_a2", wAddr[2], 10);
      checkOutput("t2_d2", wData[2], 3);
      checkOutput("t2_latency", wCyc[0] - trigCyc, 1);
      checkOutput("t2_back2back", wCyc[2] - wCyc[0], 2);
    end
    // Nothing dirty now: the next edge gives only a frame_done.
    clearLog();
    VGA_VS = 1'b0;
    tick();
    waitDone("t2b_done", 10);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t2b_count", wAddr.size(), 0);

    // Coalescing: last value wins, one write.
    applyStimulus(5, 10);
    applyStimulus(5, 20);
    clearLog();
    VGA_VS = 1'b0;
    tick();
    waitDone("t3_done", 10);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t3_count", wAddr.size(), 1);
    if (wAddr.size() == 1) begin
      checkOutput("t3_a", wAddr[0], 5);
      checkOutput("t3_d", wData[0], 20);
    end

    // Waitrequest stall: held four cycles, retired once.
    applyStimulus(2, 7);
    clearLog();
    csCycles      = 0;
    m_waitrequest = 1'b1;
    VGA_VS        = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checkOutput("t4_held_addr", m_address,   2);
    checkOutput("t4_held_data", m_writedata, 7);
    m_waitrequest = 1'b0;
    waitDone("t4_done", 10);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t4_cs_cycles", csCycles, 4);
    checkOutput("t4_count", wAddr.size(), 1);

    // Out-of-range address is accepted and discarded.
    applyStimulus(13, 99);
    clearLog();
    VGA_VS = 1'b0;
    tick();
    waitDone("t5_done", 10);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t5_count", wAddr.size(), 0);

    // All 13 dirty, stalled flush, second vsync edge mid-flush.
    for (int i = 0; i < 13; i++) applyStimulus(i, i * 7 + 1);
    clearLog();
    m_waitrequest = 1'b1;
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
    tick();
    VGA_VS = 1'b0;
    tick();
    checkOutput("t6_overrun", frame_overrun, 1);
    m_waitrequest = 1'b0;
    waitDone("t6_done", 40);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t6_count", wAddr.size(), 13);
    for (int i = 0; i < 13 && i < wAddr.size(); i++) begin
      checkOutput("t6_addr", wAddr[i], i);
      checkOutput("t6_data", wData[i], i * 7 + 1);
    end
    checkOutput("t6_overrun_sticky", frame_overrun, 1);

    // Repeat, then reset while the fourth write is on the bus.
    doReset();
    checkOutput("t6r_overrun_clr", frame_overrun, 0);
    for (int i = 0; i < 13; i++) applyStimulus(i, i + 100);
    clearLog();
    VGA_VS = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checkOutput("t6r_fourth_addr", m_address, 3);
    reset = 1'b1;
    tick();
    checkOutput("t6r_cs_after_rst",   m_chipselect, 0);
    checkOutput("t6r_addr_after_rst", m_address,    0);
    reset  = 1'b0;
    VGA_VS = 1'b1;
    repeat (20) tick();
    checkOutput("t6r_count", wAddr.size(), 3);
    // Dirty bits were lost: the next frame has nothing to write.
    VGA_VS = 1'b0;
    tick();
    waitDone("t6r_done", 10);
    VGA_VS = 1'b1;
    tick();
    checkOutput("t6r_count_after", wAddr.size(), 3);

    // Randomized run checked cycle by cycle against the model.
    vsTimer = 10;
    for (int n = 0; n < 4000; n++) begin
      upd_valid     = ($urandom_range(0, 9) < 4);
      upd_addr      = 4'($urandom_range(0, 15));
      upd_data      = 10'($urandom);
      m_waitrequest = ($urandom_range(0, 4) == 0);
      reset         = ($urandom_range(0, 599) == 0);
      vsTimer--;
      if (vsTimer <= 0) begin
        VGA_VS  = ~VGA_VS;
        vsTimer = VGA_VS ? $urandom_range(3, 40) : $urandom_range(1, 6);
      end
      tick();
    end
    reset     = 1'b0;
    upd_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
